phy_tx_nrzi: RTL

//  USB 1.1 TX line stage, directly downstream of the TX parallel-to-serial stage.

---
 rtl/phy_tx_nrzi.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/phy_tx_nrzi.sv
// USB 1.1 transmit line stage: inserts a 0 after every STUFF_LEN consecutive 1s, NRZI-encodes
// the serial stream, and drives the D+/D- pads. It also generates the SE0 and closing J of EOP.
module phy_tx_nrzi #(
  parameter int STUFF_LEN = 6,
  parameter int BIT_CLKS  = 4,
  parameter bit LOW_SPEED = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_dat,
  input  logic tx_dat_en,
  input  logic tx_nrzi_en,
  input  logic tx_se_en,
  output logic tx_nrzi_stop,
  output logic usb_dp_o,
  output logic usb_dm_o,
  output logic usb_oe
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int JW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [JW-1:0] J_LAST    = JW'(BIT_CLKS - 1);
  localparam logic [1:0]    PAD_J     = LOW_SPEED ? 2'b01 : 2'b10;
  localparam logic [1:0]    PAD_K     = LOW_SPEED ? 2'b10 : 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_SE0,
    S_EOP_J
  } state_t;

  typedef enum logic [1:0] {
    L_J,
    L_K,
    L_SE0
  } line_t;

  state_t          state_q, state_d;
  line_t           line_q, line_d;
  logic [OW-1:0]   ones_cnt_q, ones_cnt_d;
  logic [JW-1:0]   j_cnt_q, j_cnt_d;
  logic            stop_q, stop_d;
  logic            oe_q, oe_d;
  logic [1:0]      pads_q, pads_d;

  // Base for encoding a data bit: a packet's first bit always starts from idle J with no run.
  line_t           enc_line;
  logic [OW-1:0]   enc_ones;
  line_t           line_tgl;

  always_comb begin
    enc_line = (state_q == S_DATA) ? line_q : L_J;
    enc_ones = (state_q == S_DATA) ? ones_cnt_q : '0;
    line_tgl = (line_q == L_K) ? L_J : L_K;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    ones_cnt_d = ones_cnt_q;
    j_cnt_d    = j_cnt_q;
    stop_d     = 1'b0;
    oe_d       = oe_q;

    unique case (state_q)
      S_IDLE: begin
        line_d     = L_J;
        ones_cnt_d = '0;
        oe_d       = 1'b0;
        if (tx_dat_en && tx_se_en) begin
          state_d = S_SE0;
          line_d  = L_SE0;
          oe_d    = 1'b1;
        end else if (tx_dat_en && tx_nrzi_en) begin
          state_d = S_DATA;
          oe_d    = 1'b1;
          if (tx_dat) begin
            line_d     = enc_line;
            ones_cnt_d = enc_ones + OW'(1);
          end else begin
            line_d     = (enc_line == L_K) ? L_J : L_K;
            ones_cnt_d = '0;
          end
          stop_d = (ones_cnt_d == STUFF_MAX);
        end
      end

      S_DATA: begin
        oe_d   = 1'b1;
        stop_d = stop_q;
        if (tx_dat_en) begin
          // A pending stuffed 0 goes out before anything else, including SE0.
          if (stop_q) begin
            line_d     = line_tgl;
            ones_cnt_d = '0;
            stop_d     = 1'b0;
          end else if (tx_se_en) begin
            state_d = S_SE0;
            line_d  = L_SE0;
          end else if (tx_nrzi_en) begin
            if (tx_dat) begin
              ones_cnt_d = enc_ones + OW'(1);
            end else begin
              line_d     = line_tgl;
              ones_cnt_d = '0;
            end
            stop_d = (ones_cnt_d == STUFF_MAX);
          end
        end
      end

      S_SE0: begin
        oe_d   = 1'b1;
        line_d = L_SE0;
        if (tx_dat_en && !tx_se_en) begin
          state_d = S_EOP_J;
          line_d  = L_J;
          j_cnt_d = '0;
        end
      end

      S_EOP_J: begin
        oe_d   = 1'b1;
        line_d = L_J;
        if (j_cnt_q == J_LAST) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          j_cnt_d = '0;
        end else begin
          j_cnt_d = j_cnt_q + JW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        line_d  = L_J;
        oe_d    = 1'b0;
      end
    endcase

    unique case (line_d)
      L_J:     pads_d = PAD_J;
      L_K:     pads_d = PAD_K;
      default: pads_d = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      line_q     <= L_J;
      ones_cnt_q <= '0;
      j_cnt_q    <= '0;
      stop_q     <= 1'b0;
      oe_q       <= 1'b0;
      pads_q     <= PAD_J;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      ones_cnt_q <= ones_cnt_d;
      j_cnt_q    <= j_cnt_d;
      stop_q     <= stop_d;
      oe_q       <= oe_d;
      pads_q     <= pads_d;
    end
  end

  assign tx_nrzi_stop = stop_q;
  assign usb_oe       = oe_q;
  assign usb_dp_o     = pads_q[1];
  assign usb_dm_o     = pads_q[0];

  a_stop_only_in_data: assert property (@(posedge clk) disable iff (rst)
    stop_q |-> (state_q == S_DATA));

  a_ones_bounded: assert property (@(posedge clk) disable iff (rst)
    ones_cnt_q <= STUFF_MAX);

endmodule
